// File: rtl/pb_pkg.sv
// Shared defaults and counter-width helpers for the push-button debouncer.
package pb_pkg;

    localparam int PB_NUM_DEF     = 4;
    localparam int PB_DB_DEF      = 16;
    localparam int PB_LONG_DEF    = 1024;
    localparam int PB_RPT_DEF     = 0;
    localparam int PB_ACT_LOW_DEF = 1;

    function automatic int db_cnt_w(input int db);
        return (db < 1) ? 1 : $clog2(db + 1);
    endfunction

    function automatic int hold_cnt_w(input int lng, input int rpt);
        return (lng + rpt < 1) ? 1 : $clog2(lng + rpt + 1);
    endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One push-button channel: synchronizer, debounce counter, edge pulses and
// long-press / auto-repeat hold counter.
module pb_debounce_ch
    import pb_pkg::*;
#(
    parameter int DB_CYCLES     = PB_DB_DEF,
    parameter int LONG_CYCLES   = PB_LONG_DEF,
    parameter int REPEAT_CYCLES = PB_RPT_DEF,
    parameter int ACTIVE_LOW    = PB_ACT_LOW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_in,
    output logic pb_state,
    output logic pressed,
    output logic released,
    output logic long_press
);

    localparam int              DBW       = db_cnt_w(DB_CYCLES);
    localparam int              HW        = hold_cnt_w(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic            IDLE      = (ACTIVE_LOW != 0);
    localparam logic [DBW-1:0]  DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]   HOLD_LONG = HW'(LONG_CYCLES);
    localparam logic [HW-1:0]   HOLD_TOP  = HW'(LONG_CYCLES + REPEAT_CYCLES);
    localparam bit              RPT_EN    = (REPEAT_CYCLES > 0);

    logic [1:0]     r_sync;
    logic           r_lvl;
    logic           r_state;
    logic           r_state_d;
    logic           r_long;
    logic [DBW-1:0] r_db;
    logic [HW-1:0]  r_hold;

    logic           w_diff;
    logic           w_flip;
    logic           w_fall;
    logic [HW-1:0]  w_inc;

    assign w_diff = r_lvl ^ r_state;
    assign w_flip = w_diff && (r_db == DB_LAST);
    assign w_fall = w_flip && r_state;
    assign w_inc  = r_hold + HW'(1);

    // r_lvl is the normalised (1 = pressed) level, registered once more after
    // the two synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= {2{IDLE}};
            r_lvl     <= 1'b0;
            r_db      <= '0;
            r_state   <= 1'b0;
            r_state_d <= 1'b0;
            r_hold    <= '0;
            r_long    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], pb_in};
            r_lvl     <= r_sync[1] ^ IDLE;
            r_db      <= (w_diff && !w_flip) ? r_db + DBW'(1) : '0;
            r_state   <= r_state ^ w_flip;
            r_state_d <= r_state;

            // Hold counter runs only while pressed; repeat mode folds back to
            // the long threshold so the period is REPEAT_CYCLES.
            if (!r_state || w_fall) begin
                r_hold <= '0;
                r_long <= 1'b0;
            end else begin
                r_long <= (r_hold != HOLD_TOP) &&
                          ((w_inc == HOLD_LONG) || (w_inc == HOLD_TOP));
                if (RPT_EN && (w_inc == HOLD_TOP))
                    r_hold <= HOLD_LONG;
                else if (r_hold != HOLD_TOP)
                    r_hold <= w_inc;
            end
        end
    end

    assign pb_state   = r_state;
    assign pressed    = r_state & ~r_state_d;
    assign released   = ~r_state & r_state_d;
    assign long_press = r_long;

endmodule

// File: rtl/pb_debounce.sv
// Multi-channel push-button debouncer: NUM_PB independent channels.
module pb_debounce
    import pb_pkg::*;
#(
    parameter int NUM_PB        = PB_NUM_DEF,
    parameter int DB_CYCLES     = PB_DB_DEF,
    parameter int LONG_CYCLES   = PB_LONG_DEF,
    parameter int REPEAT_CYCLES = PB_RPT_DEF,
    parameter int ACTIVE_LOW    = PB_ACT_LOW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_PB-1:0] pb_in,
    output logic [NUM_PB-1:0] pb_state,
    output logic [NUM_PB-1:0] pressed,
    output logic [NUM_PB-1:0] released,
    output logic [NUM_PB-1:0] long_press
);

    if (NUM_PB < 1 || NUM_PB > 32) begin : g_bad_num
        $error("pb_debounce: NUM_PB out of range 1..32");
    end
    if (DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_bad_db
        $error("pb_debounce: DB_CYCLES out of range 1..65535");
    end
    if (LONG_CYCLES < 1 || LONG_CYCLES > (1 << 20)) begin : g_bad_long
        $error("pb_debounce: LONG_CYCLES out of range 1..2^20");
    end
    if (REPEAT_CYCLES < 0 || REPEAT_CYCLES > (1 << 20)) begin : g_bad_rpt
        $error("pb_debounce: REPEAT_CYCLES out of range 0..2^20");
    end
    if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_pol
        $error("pb_debounce: ACTIVE_LOW must be 0 or 1");
    end

    for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
        pb_debounce_ch #(
            .DB_CYCLES    (DB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .pb_in     (pb_in[i]),
            .pb_state  (pb_state[i]),
            .pressed   (pressed[i]),
            .released  (released[i]),
            .long_press(long_press[i])
        );
    end

endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce: directed scenarios plus random pin activity, checked
// every cycle against a behavioural model of the debounce / hold rules.
module tb_pb_debounce;

    localparam int DB   = 16;
    localparam int LONG = 1024;
    localparam int REPB = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pb_in;
    logic [3:0] st_a, pr_a, rl_a, lp_a;
    logic [3:0] st_b, pr_b, rl_b, lp_b;

    int checks;
    int errors;

    always #5 clk = ~clk;

    pb_debounce #(.NUM_PB(4), .DB_CYCLES(DB), .LONG_CYCLES(LONG),
                  .REPEAT_CYCLES(0), .ACTIVE_LOW(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pb_in(pb_in),
        .pb_state(st_a), .pressed(pr_a), .released(rl_a), .long_press(lp_a)
    );

    pb_debounce #(.NUM_PB(4), .DB_CYCLES(DB), .LONG_CYCLES(LONG),
                  .REPEAT_CYCLES(REPB), .ACTIVE_LOW(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pb_in(pb_in),
        .pb_state(st_b), .pressed(pr_b), .released(rl_b), .long_press(lp_b)
    );

    // Reference model: the debouncer sees the pressed-level three edges late,
    // accepts a change after DB consecutive differing samples, and long-press
    // events are derived from elapsed time since the accepted press.
    logic [3:0] h0, h1, h2;
    logic [3:0] m_st, m_prev, m_la, m_lb;
    int         m_run [4];
    int         m_rise[4];
    int         cyc;

    task automatic model_reset();
        h0 = '0; h1 = '0; h2 = '0;
        m_st = '0; m_prev = '0; m_la = '0; m_lb = '0;
        for (int c = 0; c < 4; c++) m_run[c] = 0;
    endtask

    task automatic model_edge();
        logic [3:0] seen;
        int         len;
        cyc++;
        seen = h2; h2 = h1; h1 = h0; h0 = ~pb_in;
        m_prev = m_st;
        for (int c = 0; c < 4; c++) begin
            if (seen[c] != m_st[c]) begin
                m_run[c]++;
                if (m_run[c] == DB) begin
                    m_st[c]  = ~m_st[c];
                    m_run[c] = 0;
                    if (m_st[c]) m_rise[c] = cyc;
                end
            end else begin
                m_run[c] = 0;
            end
            m_la[c] = 1'b0;
            m_lb[c] = 1'b0;
            if (m_st[c] && m_prev[c]) begin
                len = cyc - m_rise[c];
                m_la[c] = (len == LONG);
                m_lb[c] = (len >= LONG) && (((len - LONG) % REPB) == 0);
            end
        end
    endtask

    task automatic chk_vec(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_all();
        chk_vec("state_a",    st_a, m_st);
        chk_vec("pressed_a",  pr_a, m_st & ~m_prev);
        chk_vec("released_a", rl_a, ~m_st & m_prev);
        chk_vec("long_a",     lp_a, m_la);
        chk_vec("state_b",    st_b, m_st);
        chk_vec("pressed_b",  pr_b, m_st & ~m_prev);
        chk_vec("released_b", rl_b, ~m_st & m_prev);
        chk_vec("long_b",     lp_b, m_lb);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        chk_all();
    endtask

    initial begin
        int first, cnt, tp, ta, na;
        int qb[$];
        bit act;

        checks = 0; errors = 0; cyc = 0;
        for (int c = 0; c < 4; c++) m_rise[c] = 0;
        pb_in = 4'hF;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all();
        chk_int("reset_outs", int'({st_a, pr_a, rl_a, lp_a, st_b, pr_b, rl_b, lp_b}), 0);
        rst_n = 1'b1;
        repeat (10) tick();

        // Single clean press on channel 0: state rises at edge 18
        pb_in[0] = 1'b0;
        first = -1; cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (first < 0 && st_a[0]) first = i;
            if (pr_a[0]) cnt++;
        end
        chk_int("press_edge", first, 18);
        chk_int("press_pulses", cnt, 1);
        pb_in[0] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rl_a[0]) cnt++;
        end
        chk_int("release_pulses", cnt, 1);

        // 10-cycle glitch on channel 1 must be ignored everywhere
        pb_in[1] = 1'b0;
        act = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            act |= |{st_a, pr_a, rl_a};
        end
        pb_in[1] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            act |= |{st_a, pr_a, rl_a};
        end
        chk_int("glitch_activity", int'(act), 0);

        // Long hold on channel 2: single long press (A), repeats every 100 (B)
        pb_in[2] = 1'b0;
        tp = -1; ta = -1; na = 0;
        for (int i = 0; i < 1440; i++) begin
            tick();
            if (pr_a[2]) tp = i;
            if (lp_a[2]) begin na++; ta = i; end
            if (lp_b[2]) qb.push_back(i - tp);
        end
        chk_int("long_count_a", na, 1);
        chk_int("long_delay_a", ta - tp, LONG);
        chk_int("long_count_b", qb.size(), 4);
        for (int k = 0; k < 4 && k < qb.size(); k++)
            chk_int("repeat_delay_b", qb[k], LONG + k * REPB);
        pb_in[2] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rl_a[2] && rl_b[2]) cnt++;
        end
        chk_int("long_release", cnt, 1);

        // Simultaneous press on channels 0 and 3
        pb_in = 4'b0110;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pr_a == 4'b1001) cnt++;
        end
        chk_int("dual_press", cnt, 1);
        pb_in = 4'hF;
        repeat (30) tick();

        // Reset in the middle of a debounce, pin held low through it
        pb_in[0] = 1'b0;
        repeat (11) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_int("midrst_outs", int'({st_a, pr_a, rl_a, lp_a, st_b, pr_b, rl_b, lp_b}), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        first = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (first < 0 && pr_a[0]) first = i;
        end
        chk_int("rst_press_edge", first, 18);
        pb_in = 4'hF;
        repeat (30) tick();

        // Random pin activity with occasional resets
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                model_reset();
                repeat (2) tick();
                rst_n = 1'b1;
            end
            pb_in = pb_in ^ 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 40)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pb_debounce.md
PB_DEBOUNCE -- requirements
Module: pb_debounce

Interface
REQ-001 Parameter NUM_PB, default 4: number of independent push-button channels, 1..32.
REQ-002 Parameter DB_CYCLES, default 16: consecutive stable cycles required to accept a level change, 1..65535.
REQ-003 Parameter LONG_CYCLES, default 1024: held-pressed cycles before long-press event, 1..2^20.
REQ-004 Parameter REPEAT_CYCLES, default 0: auto-repeat period after long press; 0 = repeat disabled.
REQ-005 Parameter ACTIVE_LOW, default 1: 1 = pin reads 0 when pressed (idle high); 0 = pin reads 1 when pressed.
REQ-006 clk  input  1  system clock, all logic rising-edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 pb_in  input  NUM_PB  raw asynchronous button pins.
REQ-009 pb_state  output  NUM_PB  debounced level, 1 = pressed.
REQ-010 pressed  output  NUM_PB  one-cycle pulse on accepted press.
REQ-011 released  output  NUM_PB  one-cycle pulse on accepted release.
REQ-012 long_press  output  NUM_PB  one-cycle pulse at long-press threshold and at each auto-repeat.

Function
REQ-013 Each channel SHALL be independent; no state shared between channels.
REQ-014 Each pb_in bit SHALL pass a 2-flop synchronizer; output normalised to 1 = pressed per ACTIVE_LOW.
REQ-015 Debounce counter SHALL clear on any cycle synchronized level equals pb_state, else increment.
REQ-016 When counter equals DB_CYCLES-1 and level still differs, pb_state SHALL toggle and counter clear on that edge.
REQ-017 A glitch shorter than DB_CYCLES cycles (post-sync) SHALL produce no pb_state change and no pulse.
REQ-018 pressed SHALL equal pb_state & ~pb_state_d, released SHALL equal ~pb_state & pb_state_d (pb_state_d = pb_state delayed one cycle); each exactly one cycle wide.
REQ-019 Latency: clean input change before edge 0 SHALL update pb_state at edge DB_CYCLES+2; pressed/released high in the following cycle.
REQ-020 Hold counter SHALL clear while pb_state = 0 and increment each cycle while pb_state = 1, saturating at max of LONG_CYCLES and LONG_CYCLES+REPEAT_CYCLES.
REQ-021 long_press SHALL pulse one cycle when hold counter reaches LONG_CYCLES.
REQ-022 If REPEAT_CYCLES > 0, long_press SHALL pulse again every REPEAT_CYCLES cycles while held (counter reloads to LONG_CYCLES after each repeat pulse).
REQ-023 Release during or after long press SHALL still produce a released pulse; hold counter clears the cycle pb_state falls.
REQ-024 Counter widths SHALL be $clog2(DB_CYCLES+1) and $clog2(LONG_CYCLES+REPEAT_CYCLES+1); no overflow wrap permitted.
REQ-025 Simultaneous events on different channels SHALL each pulse in their own bit in the same cycle.

Reset
REQ-026 On rst_n low, synchronizer flops SHALL load idle pin level (1 if ACTIVE_LOW else 0); pb_state, pb_state_d, all counters SHALL clear; pressed, released, long_press, pb_state SHALL read 0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard progress; no pulse emitted during or first 2 cycles after reset.
REQ-028 A button held through reset release SHALL be accepted as a new press after the normal debounce latency.

Structure
REQ-029 Package pb_pkg SHALL hold default parameter constants and the width-calculation functions.
REQ-030 Single-channel sub-module pb_debounce_ch SHALL be instantiated NUM_PB times via generate.
REQ-031 Parameter illegal ranges SHALL be flagged by elaboration-time assertion.

Verification (defaults NUM_PB=4, DB_CYCLES=16, LONG_CYCLES=1024, ACTIVE_LOW=1)
REQ-032 Drive pb_in[0] 1->0 and hold -> pb_state[0] rises at edge 18, pressed[0] high one cycle; other bits stay 0.
REQ-033 Pulse pb_in[1] low for 10 cycles then high -> no pb_state, pressed or released activity on any channel.
REQ-034 Hold pb_in[2] low 2000 cycles, REPEAT_CYCLES=0 -> exactly one long_press[2] pulse 1024 cycles after pressed; release -> released[2] pulse.
REQ-035 REPEAT_CYCLES=100, hold 1400 cycles past press -> long_press pulses at hold counts 1024, 1124, 1224, 1324.
REQ-036 Assert rst_n low at debounce count 8 with pin held low, release reset -> all outputs 0, pressed pulse 18 cycles after reset release.
REQ-037 Press channels 0 and 3 on same edge -> pressed = 4'b1001 for one cycle.
